// File: rtl/ks_pipe_sub.sv
// Pipelined Kogge-Stone subtractor computing a + ~b + 1, one register stage per prefix level.
// Define KS_SUB_FLAGS_EN to build the zero/overflow flags; otherwise out_zero_o/out_ovf_o are tied low.
module ks_pipe_sub #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_a_i,
    input  logic [WIDTH-1:0] in_b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_diff_o,
    output logic             out_borrow_o,
    output logic             out_zero_o,
    output logic             out_ovf_o
);
    localparam int LEVELS = $clog2(WIDTH);

    logic                       adv;
    logic [LEVELS:0]            v_q, v_d;
    logic [LEVELS:0][WIDTH-1:0] g_q, g_d;
    logic [LEVELS:0][WIDTH-1:0] p_q, p_d;
    // Group propagate is only consumed up to the level before the last.
    logic [LEVELS-1:0][WIDTH-1:0] gp_q, gp_d;
    logic                       out_valid_q;
    logic [WIDTH-1:0]           diff_q, diff_d;
    logic                       borrow_q, borrow_d;

    // One global enable freezes every stage while the consumer stalls.
    assign adv        = ~out_valid_q | out_ready_i;
    assign in_ready_o = adv;

    always_comb begin
        // NOTE: every comb output gets a full default before the loops, so no latch can be inferred.
        v_d  = '0;
        g_d  = g_q;
        p_d  = p_q;
        gp_d = gp_q;

        v_d[0]    = in_valid_i;
        p_d[0]    = in_a_i ^ ~in_b_i;
        g_d[0]    = in_a_i & ~in_b_i;
        g_d[0][0] = g_d[0][0] | p_d[0][0];
        gp_d[0]   = p_d[0];

        for (int k = 1; k <= LEVELS; k++) begin
            v_d[k] = v_q[k-1];
            p_d[k] = p_q[k-1];
            g_d[k] = g_q[k-1];
            for (int i = (1 << (k - 1)); i < WIDTH; i++) begin
                g_d[k][i] = g_q[k-1][i] | (gp_q[k-1][i] & g_q[k-1][i - (1 << (k - 1))]);
            end
        end

        for (int k = 1; k < LEVELS; k++) begin
            gp_d[k] = gp_q[k-1];
            for (int i = (1 << (k - 1)); i < WIDTH; i++) begin
                gp_d[k][i] = gp_q[k-1][i] & gp_q[k-1][i - (1 << (k - 1))];
            end
        end

        diff_d   = p_q[LEVELS] ^ {g_q[LEVELS][WIDTH-2:0], 1'b1};
        borrow_d = ~g_q[LEVELS][WIDTH-1];
    end

`ifdef KS_SUB_FLAGS_EN
    logic [LEVELS:0] am_q, am_d, bm_q, bm_d;
    logic            zero_q, zero_d, ovf_q, ovf_d;

    always_comb begin
        am_d    = {am_q[LEVELS-1:0], in_a_i[WIDTH-1]};
        bm_d    = {bm_q[LEVELS-1:0], in_b_i[WIDTH-1]};
        zero_d  = (diff_d == '0);
        ovf_d   = (am_q[LEVELS] != bm_q[LEVELS]) & (diff_d[WIDTH-1] != am_q[LEVELS]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (adv) begin
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (adv) begin
            am_q <= am_d;
            bm_q <= bm_d;
        end
    end

    assign out_zero_o = zero_q;
    assign out_ovf_o  = ovf_q;
`else
    assign out_zero_o = 1'b0;
    assign out_ovf_o  = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so all stages shift on the same edge.
        if (rst_i) begin
            v_q         <= '0;
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
        end else if (adv) begin
            v_q         <= v_d;
            out_valid_q <= v_q[LEVELS];
            diff_q      <= diff_d;
            borrow_q    <= borrow_d;
        end
    end

    // NOTE: in-flight operand data is qualified by the valid bits, so it is left unreset.
    always_ff @(posedge clk_i) begin
        if (adv) begin
            g_q  <= g_d;
            p_q  <= p_d;
            gp_q <= gp_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_diff_o   = diff_q;
    assign out_borrow_o = borrow_q;
endmodule

// File: tb/tb_ks_pipe_sub.sv
// Self-checking bench for ks_pipe_sub: directed vectors, stall, mid-run reset and randomized traffic
// checked against an arithmetic a - b reference model.
module tb_ks_pipe_sub;
    localparam int W = 16;
`ifdef KS_SUB_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    typedef logic [W+2:0] res_t;  // {diff, borrow, zero, ovf}
    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         br;
        logic         z;
        logic         ov;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_ready, out_valid, out_borrow, out_zero, out_ovf;
    logic [W-1:0] out_diff;

    int   checks = 0;
    int   failures = 0;
    res_t exp_q[$];

    always #5 clk = ~clk;

    ks_pipe_sub #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_a_i      (in_a),
        .in_b_i      (in_b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_diff_o  (out_diff),
        .out_borrow_o(out_borrow),
        .out_zero_o  (out_zero),
        .out_ovf_o   (out_ovf)
    );

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] d;
        int           sa, sb, sd;
        logic         ov;
        d  = a - b;
        sa = int'($signed(a));
        sb = int'($signed(b));
        sd = sa - sb;
        ov = (sd >= (1 <<< (W - 1))) || (sd < -(1 <<< (W - 1)));
        return {d, (a < b), FLAGS & (a == b), FLAGS & ov};
    endfunction

    // One clock: sample handshakes at the falling edge, record accepted operands, move past the rising edge.
    task automatic step(output bit acc, output bit oxf, output bit vld, output bit rdy, output res_t obs);
        @(negedge clk);
        rdy = in_ready;
        vld = out_valid;
        acc = in_valid && in_ready && !rst;
        oxf = out_valid && out_ready;
        obs = {out_diff, out_borrow, out_zero, out_ovf};
        if (acc) exp_q.push_back(model(in_a, in_b));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bit acc, oxf, vld, rdy;
        res_t obs;
        int seen = 0;
        rst = 1'b1;
        in_valid = 1'b1;
        in_a = 16'h00AA;
        in_b = 16'h0011;
        step(acc, oxf, vld, rdy, obs);
        step(acc, oxf, vld, rdy, obs);
        rst = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_diff !== '0) begin failures++; $display("FAIL reset_diff got=%h exp=0", out_diff); end
        checks++; if ({out_borrow, out_zero, out_ovf} !== 3'b000) begin
            failures++; $display("FAIL reset_flags got=%b exp=000", {out_borrow, out_zero, out_ovf});
        end
        for (int n = 0; n < 10; n++) begin
            step(acc, oxf, vld, rdy, obs);
            if (vld) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL reset_no_accept got=%0d exp=0", seen); end
        exp_q.delete();
    endtask

    task automatic test_directed();
        vec_t vecs[5];
        bit acc, oxf, vld, rdy;
        res_t obs, want;
        int lat;
        vecs[0] = '{16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        out_ready = 1'b1;
        foreach (vecs[j]) begin
            in_a = vecs[j].a;
            in_b = vecs[j].b;
            in_valid = 1'b1;
            step(acc, oxf, vld, rdy, obs);
            in_valid = 1'b0;
            checks++; if (acc !== 1'b1) begin failures++; $display("FAIL dir_accept[%0d] got=%b exp=1", j, acc); end
            lat = 0;
            for (int n = 1; n <= 12; n++) begin
                step(acc, oxf, vld, rdy, obs);
                if (oxf) begin
                    lat = n;
                    break;
                end
            end
            want = {vecs[j].d, vecs[j].br, FLAGS & vecs[j].z, FLAGS & vecs[j].ov};
            checks++; if (lat != 6) begin failures++; $display("FAIL dir_latency[%0d] got=%0d exp=6", j, lat); end
            checks++; if (obs !== want) begin failures++; $display("FAIL dir_result[%0d] got=%h exp=%h", j, obs, want); end
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ops_a[8], ops_b[8];
        bit acc, oxf, vld, rdy, exp_rdy;
        res_t obs, want, hold;
        int idx = 0;
        int got = 0;
        for (int j = 0; j < 8; j++) begin
            ops_a[j] = W'($urandom);
            ops_b[j] = W'($urandom);
        end
        hold = '0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            in_valid = (idx < 8);
            in_a = ops_a[idx % 8];
            in_b = ops_b[idx % 8];
            out_ready = !(cyc >= 7 && cyc <= 9);
            step(acc, oxf, vld, rdy, obs);
            exp_rdy = !(cyc >= 7 && cyc <= 9);
            if (cyc < 20) begin
                checks++; if (rdy !== exp_rdy) begin failures++; $display("FAIL b2b_in_ready[c%0d] got=%b exp=%b", cyc, rdy, exp_rdy); end
            end
            if (cyc == 7) hold = obs;
            if (cyc == 8 || cyc == 9) begin
                checks++; if (vld !== 1'b1 || obs !== hold) begin
                    failures++; $display("FAIL b2b_hold[c%0d] got=%b/%h exp=1/%h", cyc, vld, obs, hold);
                end
            end
            if (acc && idx == 7) begin
                checks++; if (cyc != 10) begin failures++; $display("FAIL b2b_release_accept got=c%0d exp=c10", cyc); end
            end
            if (acc) idx++;
            if (oxf) begin
                got++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL b2b_extra got=%h exp=none", obs);
                end else begin
                    want = exp_q.pop_front();
                    if (obs !== want) begin failures++; $display("FAIL b2b_order[%0d] got=%h exp=%h", got, obs, want); end
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++; if (got != 8 || exp_q.size() != 0) begin
            failures++; $display("FAIL b2b_count got=%0d exp=8 left=%0d", got, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        bit acc, oxf, vld, rdy;
        res_t obs, want;
        int seen = 0;
        int lat = 0;
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            in_a = W'($urandom);
            in_b = W'($urandom);
            in_valid = 1'b1;
            step(acc, oxf, vld, rdy, obs);
        end
        rst = 1'b1;
        step(acc, oxf, vld, rdy, obs);
        rst = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL mid_reset_state got=%b%b exp=01", out_valid, in_ready);
        end
        for (int n = 0; n < 2; n++) begin
            step(acc, oxf, vld, rdy, obs);
            if (vld) seen++;
        end
        in_a = 16'h4321;
        in_b = 16'h0321;
        in_valid = 1'b1;
        step(acc, oxf, vld, rdy, obs);
        in_valid = 1'b0;
        if (vld) seen++;
        for (int n = 1; n <= 12; n++) begin
            step(acc, oxf, vld, rdy, obs);
            if (oxf) begin
                lat = n;
                break;
            end
            if (vld) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL mid_reset_stale got=%0d exp=0", seen); end
        checks++; if (lat != 6) begin failures++; $display("FAIL mid_reset_latency got=%0d exp=6", lat); end
        want = {16'h4000, 1'b0, 1'b0, 1'b0};
        checks++; if (obs !== want) begin failures++; $display("FAIL mid_reset_result got=%h exp=%h", obs, want); end
        exp_q.delete();
    endtask

    task automatic test_random();
        bit acc, oxf, vld, rdy;
        res_t obs, want;
        int got = 0;
        int cyc = 0;
        int r;
        while (got < 10000 && cyc < 40000) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_a = W'($urandom);
            r = $urandom_range(0, 7);
            case (r)
                0: in_b = in_a;
                1: in_b = in_a + 1'b1;
                2: begin in_a = '0; in_b = W'($urandom); end
                3: begin in_a = {1'b1, {(W-1){1'b0}}}; in_b = W'($urandom); end
                default: in_b = W'($urandom);
            endcase
            step(acc, oxf, vld, rdy, obs);
            cyc++;
            if (oxf) begin
                got++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL rand_extra got=%h exp=none", obs);
                end else begin
                    want = exp_q.pop_front();
                    if (obs !== want) begin failures++; $display("FAIL rand_result[%0d] got=%h exp=%h", got, obs, want); end
                end
            end
        end
        checks++; if (got < 10000) begin failures++; $display("FAIL rand_timeout got=%0d exp=10000", got); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            step(acc, oxf, vld, rdy, obs);
            if (oxf) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL rand_drain_extra got=%h exp=none", obs);
                end else begin
                    want = exp_q.pop_front();
                    if (obs !== want) begin failures++; $display("FAIL rand_drain got=%h exp=%h", obs, want); end
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rand_lost got=%0d exp=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
